// File: rtl/minmax_pkg.sv
// Shared types and width helpers for the minimum/maximum reduction blocks.
package minmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } reducer_state_e;

  // Wide enough to hold every value from 0 to max_terms inclusive.
  function automatic int count_width(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

  function automatic int index_width(input int max_terms);
    return (max_terms > 1) ? $clog2(max_terms) : 1;
  endfunction

  localparam int EMPTY_RESULT = 0;

endpackage

// File: rtl/minimum_c2_compare_stage.sv
// Combinational compare-with-activation cell: strict less-than mirror of the maximum cell.
module minimum_c2_compare_stage #(
  parameter int NUMBER_SIZE = 4
) (
  input  logic signed [NUMBER_SIZE-1:0] candidate,
  input  logic                          activation,
  input  logic signed [NUMBER_SIZE-1:0] current_min,
  input  logic                          have_active,
  output logic                          replace,
  output logic signed [NUMBER_SIZE-1:0] next_min
);

  // Strict less-than keeps the earlier value on ties.
  assign replace  = activation && (!have_active || (candidate < current_min));
  assign next_min = replace ? candidate : current_min;

endmodule

// File: rtl/minimum_c2_serial_reducer.sv
// Serial minimum-with-activation reducer over a valid/ready beat stream.
// Optional MIN_C2_INDEX_EN adds out_index, the beat position of the winning candidate.
module minimum_c2_serial_reducer
  import minmax_pkg::*;
#(
  parameter int NUMBER_SIZE = 4,
  parameter int MAX_TERMS   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [NUMBER_SIZE-1:0]        in_number,
  input  logic                                 in_activation,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [NUMBER_SIZE-1:0]        out_minimum,
  output logic                                 out_activation,
  output logic [count_width(MAX_TERMS)-1:0]    out_count,
  output logic                                 out_truncated
`ifdef MIN_C2_INDEX_EN
  ,
  output logic [index_width(MAX_TERMS)-1:0]    out_index
`endif
);

  localparam int COUNT_W = count_width(MAX_TERMS);
  localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(MAX_TERMS - 1);
  localparam logic signed [NUMBER_SIZE-1:0] EMPTY_VALUE = NUMBER_SIZE'(EMPTY_RESULT);

  reducer_state_e               state;
  logic signed [NUMBER_SIZE-1:0] run_min;
  logic signed [NUMBER_SIZE-1:0] next_min;
  logic [COUNT_W-1:0]           run_count;
  logic [COUNT_W-1:0]           beat_cnt;
  logic                         act_seen;
  logic                         truncated;
  logic                         replace;
  logic                         accept;
  logic                         terminate;

`ifdef MIN_C2_INDEX_EN
  localparam int INDEX_W = index_width(MAX_TERMS);
  logic [INDEX_W-1:0] run_index;
  assign out_index = run_index;
`endif

  // Handshake flags decode state only, so no combinational path from in_valid/out_ready.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign terminate = accept && (in_last || (beat_cnt == LAST_BEAT));

  minimum_c2_compare_stage #(
    .NUMBER_SIZE (NUMBER_SIZE)
  ) u_compare (
    .candidate   (in_number),
    .activation  (in_activation),
    .current_min (run_min),
    .have_active (act_seen),
    .replace     (replace),
    .next_min    (next_min)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      run_min   <= EMPTY_VALUE;
      run_count <= '0;
      beat_cnt  <= '0;
      act_seen  <= 1'b0;
      truncated <= 1'b0;
`ifdef MIN_C2_INDEX_EN
      run_index <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            run_min  <= next_min;
            beat_cnt <= beat_cnt + 1'b1;
            if (in_activation) begin
              run_count <= run_count + 1'b1;
              act_seen  <= 1'b1;
            end
`ifdef MIN_C2_INDEX_EN
            if (replace) run_index <= beat_cnt[INDEX_W-1:0];
`endif
            if (terminate) begin
              state     <= HOLD;
              truncated <= !in_last;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            run_min   <= EMPTY_VALUE;
            run_count <= '0;
            beat_cnt  <= '0;
            act_seen  <= 1'b0;
            truncated <= 1'b0;
`ifdef MIN_C2_INDEX_EN
            run_index <= '0;
`endif
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign out_minimum    = run_min;
  assign out_activation = act_seen;
  assign out_count      = run_count;
  assign out_truncated  = truncated;

endmodule

// File: tb/tb_minimum_c2_serial_reducer.sv
// Self-checking bench for minimum_c2_serial_reducer: directed cases then random
// reductions checked against a queue-based reference model.
module tb_minimum_c2_serial_reducer;

  localparam int NS = 4;
  localparam int MT = 8;
  localparam int CW = $clog2(MT + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NS-1:0] in_number = '0;
  logic          in_activation = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NS-1:0] out_minimum;
  logic          out_activation;
  logic [CW-1:0] out_count;
  logic          out_truncated;
`ifdef MIN_C2_INDEX_EN
  logic [$clog2(MT)-1:0] out_index;
`endif

  minimum_c2_serial_reducer #(
    .NUMBER_SIZE (NS),
    .MAX_TERMS   (MT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_number      (in_number),
    .in_activation  (in_activation),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_minimum    (out_minimum),
    .out_activation (out_activation),
    .out_count      (out_count),
    .out_truncated  (out_truncated)
`ifdef MIN_C2_INDEX_EN
    ,
    .out_index      (out_index)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] num;
    bit            act;
  } beat_t;

  beat_t         model_q[$];
  logic [NS-1:0] exp_min;
  bit            exp_act;
  int            exp_cnt;
  int            exp_idx;
  bit            exp_trunc;
  bit            result_due;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: minimum over active beats, first occurrence wins, count of actives.
  task automatic model_close(input bit last);
    exp_act   = 1'b0;
    exp_min   = '0;
    exp_cnt   = 0;
    exp_idx   = 0;
    exp_trunc = !last;
    foreach (model_q[i]) begin
      if (model_q[i].act) begin
        if (!exp_act || $signed(model_q[i].num) < $signed(exp_min)) begin
          exp_min = model_q[i].num;
          exp_idx = i;
        end
        exp_act = 1'b1;
        exp_cnt++;
      end
    end
    model_q.delete();
    result_due = 1'b1;
  endtask

  task automatic send_beat(input logic [NS-1:0] num, input bit act, input bit last);
    @(negedge clk);
    check("accum_in_ready", {31'b0, in_ready}, 1);
    in_valid      = 1'b1;
    in_number     = num;
    in_activation = act;
    in_last       = last;
    model_q.push_back('{num, act});
    if (last || model_q.size() == MT) model_close(last);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"},     {31'b0, out_valid}, 1);
    check({tag, "_in_ready"},  {31'b0, in_ready}, 0);
    check({tag, "_minimum"},   {28'b0, out_minimum}, {28'b0, exp_min});
    check({tag, "_activation"}, {31'b0, out_activation}, {31'b0, exp_act});
    check({tag, "_count"},     32'(out_count), exp_cnt);
    check({tag, "_truncated"}, {31'b0, out_truncated}, {31'b0, exp_trunc});
`ifdef MIN_C2_INDEX_EN
    check({tag, "_index"},     32'(out_index), exp_idx);
`endif
  endtask

  // Terminating beat was accepted on the last edge; result must be visible now.
  task automatic take_result(input string tag, input int stall);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result(tag);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_result({tag, "_stall"});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, {31'b0, out_valid}, 0);
    check({tag, "_release_ready"}, {31'b0, in_ready}, 1);
    result_due = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   {31'b0, in_ready}, 1);
    check({tag, "_out_valid"},  {31'b0, out_valid}, 0);
    check({tag, "_minimum"},    {28'b0, out_minimum}, 0);
    check({tag, "_activation"}, {31'b0, out_activation}, 0);
    check({tag, "_count"},      32'(out_count), 0);
    check({tag, "_truncated"},  {31'b0, out_truncated}, 0);
`ifdef MIN_C2_INDEX_EN
    check({tag, "_index"},      32'(out_index), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    result_due = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 3, -2, 5 all active
    send_beat(4'd3, 1'b1, 1'b0);
    send_beat(4'hE, 1'b1, 1'b0);
    send_beat(4'd5, 1'b1, 1'b1);
    take_result("basic", 0);

    // inactive -8 ignored
    send_beat(4'h8, 1'b0, 1'b0);
    send_beat(4'd6, 1'b1, 1'b0);
    send_beat(4'd7, 1'b1, 1'b1);
    take_result("inactive", 0);

    // all inactive
    send_beat(4'h9, 1'b0, 1'b0);
    send_beat(4'd2, 1'b0, 1'b1);
    take_result("empty", 0);

    // ties keep earliest position
    send_beat(4'd5, 1'b0, 1'b0);
    send_beat(4'hD, 1'b1, 1'b0);
    send_beat(4'hD, 1'b1, 1'b1);
    take_result("tie", 0);

    // eight beats without last: truncation, 9th beat is a new single-beat reduction
    for (int i = 0; i < MT; i++) send_beat(NS'(7 - i), 1'(i % 3 != 0), 1'b0);
    check("trunc_model_due", {31'b0, result_due}, 1);
    take_result("trunc", 0);
    send_beat(4'hB, 1'b1, 1'b1);
    take_result("single", 0);

    // last on beat MAX_TERMS is not a truncation
    for (int i = 0; i < MT; i++) send_beat(NS'(i), 1'b1, 1'(i == MT - 1));
    take_result("full_last", 0);

    // held result under backpressure
    send_beat(4'd1, 1'b1, 1'b0);
    send_beat(4'hC, 1'b1, 1'b1);
    take_result("stall", 5);

    // reset mid-reduction drops the partial result
    send_beat(4'hA, 1'b1, 1'b0);
    send_beat(4'hF, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_q.delete();
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(4'd4, 1'b1, 1'b0);
    send_beat(4'd2, 1'b1, 1'b1);
    take_result("after_reset", 0);

    // random reductions
    for (int r = 0; r < 40; r++) begin
      while (!result_due)
        send_beat(NS'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      take_result("random", $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
